// File: rtl/bpi_al_pkg.sv
// Shared constants, state encoding and status bit positions for the BPI auto-loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bpi_al_pkg;

  // Flash "read array" command word and the sequencer opcode for a read.
  localparam logic [15:0] Read_Array_Cmd = 16'h00FF;
  localparam logic [1:0]  OP_READ        = 2'b10;

  // Bit positions inside AL_STATUS = {aborted, completed, running}.
  localparam int ST_RUN   = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_ABORT = 2;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    WAIT_BUSY,
    WAIT_DONE,
    WRITE,
    NEXT,
    COMPLETE,
    ABORT
  } al_state_t;

endpackage

// File: rtl/bpi_al_fsm.sv
// Load sequencing FSM: state register, word counter and per-phase handshake timeout.
// Latency: 5 cycles per word (EXEC, WAIT_BUSY, WAIT_DONE, WRITE, NEXT) with an immediate sequencer.
// Backpressure: waits on BUSY/AL_DONE for at most TIMEOUT cycles per phase, then aborts.
module bpi_al_fsm
  import bpi_al_pkg::*;
#(
  parameter int NUM_WORDS = 34,
  parameter int CNT_W     = 6,
  parameter int TIMEOUT   = 1023,
  parameter int TO_W      = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             al_start_i,
  input  logic             al_abort_i,
  input  logic             busy_i,
  input  logic             al_done_i,
  output al_state_t        state_q_o,
  output al_state_t        state_d_o,
  output logic [CNT_W-1:0] cnt_q_o,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             start_o,
  output logic             capture_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  al_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             start, capture;
  logic             in_wait, timed_out, abortable;

  assign in_wait   = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign timed_out = (to_q == TO_LAST);
  // Abort is honoured everywhere a load is in flight except the final status cycles.
  assign abortable = (state_q != IDLE) && (state_q != COMPLETE) && (state_q != ABORT);

  // Next-state, counter and timeout decode; an external abort overrides every other move.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (al_start_i) begin
          state_d = EXEC;
          cnt_d   = '0;
          start   = 1'b1;
        end
      end
      EXEC:      state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy_i) begin
          state_d = WAIT_DONE;
        end else if (al_done_i) begin
          // Sequencer finished before BUSY was ever seen.
          state_d = WRITE;
          capture = 1'b1;
        end else if (timed_out) begin
          state_d = ABORT;
        end
      end
      WAIT_DONE: begin
        if (!busy_i && al_done_i) begin
          state_d = WRITE;
          capture = 1'b1;
        end else if (timed_out) begin
          state_d = ABORT;
        end
      end
      WRITE:     state_d = NEXT;
      NEXT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = COMPLETE;
        end else begin
          state_d = EXEC;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      COMPLETE:  state_d = IDLE;
      ABORT:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (al_abort_i && abortable) begin
      state_d = ABORT;
      cnt_d   = cnt_q;
      capture = 1'b0;
    end

    // Timeout counts only while parked in a wait state; any state change restarts it.
    if (in_wait && (state_d == state_q)) begin
      to_d = to_q + TO_W'(1);
    end else begin
      to_d = '0;
    end
  end

  // State, word counter and timeout registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign state_q_o = state_q;
  assign state_d_o = state_d;
  assign cnt_q_o   = cnt_q;
  assign cnt_d_o   = cnt_d;
  assign start_o   = start;
  assign capture_o = capture;

endmodule

// File: rtl/bpi_auto_loader.sv
// Flash-to-register auto-loader: reads NUM_WORDS words from one of two flash banks into the constant store.
// Latency: 5 cycles per word with an immediate sequencer, plus one COMPLETE cycle; AL_ADDR is registered.
// Backpressure: stalls on the sequencer BUSY/AL_DONE handshake, aborting after TIMEOUT cycles or on AL_ABORT.
// Optional: define BPI_AL_CHECKSUM_EN to verify the last word as a negated-sum checksum.
module bpi_auto_loader
  import bpi_al_pkg::*;
#(
  parameter int                ADDR_W     = 23,
  parameter int                DATA_W     = 16,
  parameter int                NUM_WORDS  = 34,
  parameter int                CNT_W      = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR0 = 23'h7FC000,
  parameter logic [ADDR_W-1:0] BASE_ADDR1 = 23'h7F8000,
  parameter int                TIMEOUT    = 1023,
  parameter int                TO_W       = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              AL_START,
  input  logic              AL_ABORT,
  input  logic              AL_BANK,
  input  logic              BUSY,
  input  logic              AL_DONE,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic [ADDR_W-1:0] AL_ADDR,
  output logic [DATA_W-1:0] AL_CMD_DATA_OUT,
  output logic [1:0]        AL_OP,
  output logic              AL_EXECUTE,
  output logic              AUTO_LOAD_ENA,
  output logic              CLR_AL_DONE,
  output logic              WR_EN,
  output logic [CNT_W-1:0]  WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic [CNT_W-1:0]  AL_CNT,
  output logic [2:0]        AL_STATUS
);

  al_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start, capture;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        status_q, status_d;
  logic              chk_err;

  bpi_al_fsm #(
    .NUM_WORDS (NUM_WORDS),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .TO_W      (TO_W)
  ) u_fsm (
    .CLK        (CLK),
    .RST        (RST),
    .al_start_i (AL_START),
    .al_abort_i (AL_ABORT),
    .busy_i     (BUSY),
    .al_done_i  (AL_DONE),
    .state_q_o  (state_q),
    .state_d_o  (state_d),
    .cnt_q_o    (cnt_q),
    .cnt_d_o    (cnt_d),
    .start_o    (start),
    .capture_o  (capture)
  );

  // Bank base latched at start; address computed from the next counter so it is valid in EXEC.
  always_comb begin
    base_d = base_q;
    addr_d = addr_q;
    data_d = data_q;
    if (start) begin
      base_d = AL_BANK ? BASE_ADDR1 : BASE_ADDR0;
    end
    if (state_d == EXEC) begin
      addr_d = base_d + ADDR_W'(cnt_d);
    end
    if (capture) begin
      data_d = RD_DATA;
    end
  end

  // Sticky status: set to running at start, resolved to completed/aborted on the final cycle.
  always_comb begin
    status_d = status_q;
    if (start) begin
      status_d         = '0;
      status_d[ST_RUN] = 1'b1;
    end else if (state_q == COMPLETE) begin
      status_d           = '0;
      status_d[ST_DONE]  = 1'b1;
      status_d[ST_ABORT] = chk_err;
    end else if (state_q == ABORT) begin
      status_d[ST_ABORT] = 1'b1;
      status_d[ST_RUN]   = 1'b0;
    end
  end

  // Address, capture and status registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      base_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      base_q   <= base_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

`ifdef BPI_AL_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  // Running mod-2**DATA_W sum of every word written; the checksum word drives it to zero.
  always_comb begin
    sum_d = sum_q;
    if (start) begin
      sum_d = '0;
    end else if (state_q == WRITE) begin
      sum_d = sum_q + data_q;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign chk_err = |sum_q;
`else
  assign chk_err = 1'b0;
`endif

  assign AL_ADDR         = addr_q;
  assign AL_CMD_DATA_OUT = DATA_W'(Read_Array_Cmd);
  assign AL_OP           = OP_READ;
  assign AL_EXECUTE      = (state_q == EXEC);
  assign AUTO_LOAD_ENA   = (state_q != IDLE);
  assign CLR_AL_DONE     = (state_q == WRITE) || (state_q == ABORT);
  assign WR_EN           = (state_q == WRITE);
  assign WR_ADDR         = cnt_q;
  assign WR_DATA         = data_q;
  assign AL_CNT          = cnt_q;
  assign AL_STATUS       = status_q;

endmodule

// File: tb/tb_bpi_auto_loader.sv
// Scoreboard bench for bpi_auto_loader with a behavioural BPI sequencer model.
// Latency: n/a.
// Backpressure: sequencer model drives BUSY for a programmable number of cycles.
module tb_bpi_auto_loader;

  localparam logic [22:0] B0 = 23'h7FC000;
  localparam logic [22:0] B1 = 23'h7F8000;
`ifdef BPI_AL_CHECKSUM_EN
  localparam logic [2:0] ST_PLAIN = 3'b110;  // ramp data has a nonzero sum
`else
  localparam logic [2:0] ST_PLAIN = 3'b010;
`endif
  localparam logic [2:0] ST_ABRT = 3'b100;

  logic        CLK, RST, AL_START, AL_ABORT, AL_BANK, BUSY, AL_DONE;
  logic [15:0] RD_DATA;
  logic [22:0] AL_ADDR;
  logic [15:0] AL_CMD_DATA_OUT, WR_DATA;
  logic [1:0]  AL_OP;
  logic        AL_EXECUTE, AUTO_LOAD_ENA, CLR_AL_DONE, WR_EN;
  logic [5:0]  WR_ADDR, AL_CNT;
  logic [2:0]  AL_STATUS;

  bpi_auto_loader dut (
    .CLK(CLK), .RST(RST), .AL_START(AL_START), .AL_ABORT(AL_ABORT), .AL_BANK(AL_BANK),
    .BUSY(BUSY), .AL_DONE(AL_DONE), .RD_DATA(RD_DATA), .AL_ADDR(AL_ADDR),
    .AL_CMD_DATA_OUT(AL_CMD_DATA_OUT), .AL_OP(AL_OP), .AL_EXECUTE(AL_EXECUTE),
    .AUTO_LOAD_ENA(AUTO_LOAD_ENA), .CLR_AL_DONE(CLR_AL_DONE), .WR_EN(WR_EN),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .AL_CNT(AL_CNT), .AL_STATUS(AL_STATUS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [22:0] addr;
    logic [5:0]  idx;
    logic [15:0] data;
  } wr_exp_t;

  wr_exp_t     exp_q[$];
  logic [2:0]  st_q[$];
  logic [15:0] word_data [34];
  int          dead_idx = -1;
  int          busy_len = 2;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sequencer model: BUSY for busy_len cycles after EXECUTE, then sticky AL_DONE with data.
  initial begin
    bit         pending = 0;
    int         bcnt = 0;
    logic [5:0] pidx = '0;
    BUSY = 0; AL_DONE = 0; RD_DATA = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        BUSY = 0; AL_DONE = 0; pending = 0; bcnt = 0;
      end else begin
        if (CLR_AL_DONE) AL_DONE = 0;
        if (AL_EXECUTE && int'(AL_CNT) != dead_idx) begin
          pending = 1; pidx = AL_CNT; bcnt = busy_len;
        end
        if (pending) begin
          if (bcnt > 0) begin
            BUSY = 1; bcnt--;
          end else begin
            BUSY = 0; AL_DONE = 1; RD_DATA = word_data[pidx]; pending = 0;
          end
        end
      end
    end
  end

  // Monitor: pop an expected write on every WR_EN, an expected status whenever the loader goes idle.
  initial begin
    logic    ena_prev = 1'b0;
    wr_exp_t e;
    logic [2:0] s;
    forever begin
      @(negedge CLK);
      if (WR_EN) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_en", {26'd0, WR_ADDR}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {26'd0, WR_ADDR}, {26'd0, e.idx});
          chk("wr_data", {16'd0, WR_DATA}, {16'd0, e.data});
          chk("al_addr", {9'd0, AL_ADDR}, {9'd0, e.addr});
        end
      end
      if (ena_prev && !AUTO_LOAD_ENA) begin
        if (st_q.size() == 0) begin
          chk("unexpected_idle", {29'd0, AL_STATUS}, 32'hFFFF_FFFF);
        end else begin
          s = st_q.pop_front();
          chk("al_status", {29'd0, AL_STATUS}, {29'd0, s});
        end
      end
      ena_prev = AUTO_LOAD_ENA;
    end
  end

  task automatic expect_load(input logic bank, input int nwr, input logic [2:0] st);
    logic [22:0] base;
    base = bank ? B1 : B0;
    for (int i = 0; i < nwr; i++) exp_q.push_back({base + 23'(i), 6'(i), word_data[i]});
    st_q.push_back(st);
  endtask

  task automatic start_pulse(input logic bank, input logic abort_too);
    @(negedge CLK);
    AL_START = 1; AL_BANK = bank; AL_ABORT = abort_too;
    @(negedge CLK);
    AL_START = 0; AL_ABORT = 0;
  endtask

  task automatic wait_exec(input int idx);
    bit found = 0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge CLK);
      if (AL_EXECUTE && int'(AL_CNT) == idx) found = 1;
    end
    chk("exec_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int n = 0; n < 3000 && !idle; n++) begin
      @(negedge CLK);
      if (!AUTO_LOAD_ENA) idle = 1;
    end
    chk("load_finished", {31'd0, idle}, 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    chk("wr_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("st_queue_empty", 32'(st_q.size()), 32'd0);
  endtask

  task automatic ramp_data();
    for (int i = 0; i < 34; i++) word_data[i] = 16'h0100 + 16'(i);
  endtask

  initial begin
    int n;
    RST = 1; AL_START = 0; AL_ABORT = 0; AL_BANK = 0;
    ramp_data();
    repeat (3) @(negedge CLK);
    // Reset values
    chk("rst_addr", {9'd0, AL_ADDR}, 32'd0);
    chk("rst_ena", {31'd0, AUTO_LOAD_ENA}, 32'd0);
    chk("rst_exec", {31'd0, AL_EXECUTE}, 32'd0);
    chk("rst_wr_en", {31'd0, WR_EN}, 32'd0);
    chk("rst_status", {29'd0, AL_STATUS}, 32'd0);
    chk("rst_cmd", {16'd0, AL_CMD_DATA_OUT}, 32'h00FF);
    chk("rst_op", {30'd0, AL_OP}, 32'd2);
    RST = 0;
    @(negedge CLK);

    // Bank 0 full load with 2-cycle BUSY
    expect_load(1'b0, 34, ST_PLAIN);
    start_pulse(1'b0, 1'b0);
    chk("run_status", {29'd0, AL_STATUS}, 32'b001);
    wait_idle();

    // Abort in IDLE has no effect
    AL_ABORT = 1;
    @(negedge CLK);
    AL_ABORT = 0;
    @(negedge CLK);
    chk("idle_abort_status", {29'd0, AL_STATUS}, {29'd0, ST_PLAIN});
    chk("idle_abort_ena", {31'd0, AUTO_LOAD_ENA}, 32'd0);

    // Bank 1 load; AL_START mid-load is ignored
    expect_load(1'b1, 34, ST_PLAIN);
    start_pulse(1'b1, 1'b0);
    wait_exec(3);
    @(negedge CLK);
    AL_START = 1;
    @(negedge CLK);
    AL_START = 0;
    chk("restart_ignored_cnt", {26'd0, AL_CNT}, 32'd3);
    chk("restart_ignored_status", {29'd0, AL_STATUS}, 32'b001);
    wait_idle();

    // Fast sequencer (no BUSY phase)
    busy_len = 0;
    expect_load(1'b0, 34, ST_PLAIN);
    start_pulse(1'b0, 1'b0);
    wait_idle();
    busy_len = 2;

    // Timeout on word 5: sequencer never responds
    dead_idx = 5;
    expect_load(1'b0, 5, ST_ABRT);
    start_pulse(1'b0, 1'b0);
    wait_exec(5);
    n = 0;
    while (!CLR_AL_DONE && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd1024);
    chk("timeout_clr", {31'd0, CLR_AL_DONE}, 32'd1);
    wait_idle();
    dead_idx = -1;

    // External abort in WAIT_DONE of word 10
    expect_load(1'b0, 10, ST_ABRT);
    start_pulse(1'b0, 1'b0);
    wait_exec(10);
    @(negedge CLK);
    @(negedge CLK);
    AL_ABORT = 1;
    @(negedge CLK);
    AL_ABORT = 0;
    chk("abort_clr", {31'd0, CLR_AL_DONE}, 32'd1);
    chk("abort_no_wr", {31'd0, WR_EN}, 32'd0);
    wait_idle();

    // Clean reload, with AL_ABORT coincident with AL_START (start wins)
    expect_load(1'b1, 34, ST_PLAIN);
    start_pulse(1'b1, 1'b1);
    chk("start_beats_abort", {31'd0, AUTO_LOAD_ENA}, 32'd1);
    wait_idle();

    // Reset mid-load
    expect_load(1'b0, 7, 3'b000);
    start_pulse(1'b0, 1'b0);
    wait_exec(7);
    RST = 1;
    @(negedge CLK);
    chk("midrst_addr", {9'd0, AL_ADDR}, 32'd0);
    chk("midrst_cnt", {26'd0, AL_CNT}, 32'd0);
    chk("midrst_wr_data", {16'd0, WR_DATA}, 32'd0);
    chk("midrst_status", {29'd0, AL_STATUS}, 32'd0);
    RST = 0;
    @(negedge CLK);
    chk("postrst_ena", {31'd0, AUTO_LOAD_ENA}, 32'd0);
    chk("postrst_wr_en", {31'd0, WR_EN}, 32'd0);
    wait_idle();

    // Checksum word: correct negated sum of 0x100..0x120 is 0xDCF0
    word_data[33] = 16'hDCF0;
    expect_load(1'b0, 34, 3'b010);
    start_pulse(1'b0, 1'b0);
    wait_idle();

    // Corrupted checksum word
    word_data[33] = 16'hDCF1;
`ifdef BPI_AL_CHECKSUM_EN
    expect_load(1'b0, 34, 3'b110);
`else
    expect_load(1'b0, 34, 3'b010);
`endif
    start_pulse(1'b0, 1'b0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpi_auto_loader.md
Name: bpi_auto_loader

Overview:
- Parametrised flash-to-register auto-loader for the BPI interface.
- On AL_START it reads NUM_WORDS consecutive 16-bit words from one of two selectable parameter blocks in flash and writes each word to the constant store.
- Adds three things to the fixed-size loader: a bank select, per-word BUSY/DONE timeouts, and an external abort.
- Sits between the BPI command sequencer (BUSY/AL_DONE handshake) and the constant register file.

Parameters:
- ADDR_W, 23, flash word-address width
- DATA_W, 16, flash data width
- NUM_WORDS, 34, words per load (1..2**CNT_W)
- CNT_W, 6, word counter width
- BASE_ADDR0, 23'h7FC000, bank-0 base address
- BASE_ADDR1, 23'h7F8000, bank-1 base address
- TIMEOUT, 1023, max cycles waiting on any single handshake phase
- TO_W, 10, timeout counter width

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- AL_START  in  1  one-cycle load request; ignored unless IDLE
- AL_ABORT  in  1  abort current load
- AL_BANK  in  1  base select, sampled at AL_START
- BUSY  in  1  sequencer busy
- AL_DONE  in  1  sequencer read-data valid (sticky until CLR_AL_DONE)
- RD_DATA  in  DATA_W  flash read data, valid with AL_DONE
- AL_ADDR  out  ADDR_W  flash address
- AL_CMD_DATA_OUT  out  DATA_W  constant 16'h00FF (read array)
- AL_OP  out  2  constant 2'b10 (read)
- AL_EXECUTE  out  1  one-cycle command strobe
- AUTO_LOAD_ENA  out  1  high while not IDLE; muxes loader onto the BPI bus
- CLR_AL_DONE  out  1  one-cycle clear of sequencer AL_DONE
- WR_EN  out  1  one-cycle write strobe to constant store
- WR_ADDR  out  CNT_W  store index
- WR_DATA  out  DATA_W  store data
- AL_CNT  out  CNT_W  current word index
- AL_STATUS  out  3  {aborted, completed, running}, sticky

Behaviour:
- Reset values:
  - All outputs 0, except the constants AL_CMD_DATA_OUT and AL_OP.
  - FSM in IDLE.
- Addressing:
  - AL_ADDR = base + zero-extended AL_CNT, with base latched from AL_BANK at start.
  - Full adder, no alignment requirement.
  - Registered, and stable from EXECUTE until the word completes.
- FSM states: IDLE, EXEC, WAIT_BUSY, WAIT_DONE, WRITE, NEXT, COMPLETE, ABORT.
- IDLE:
  - AL_START → EXEC.
  - On entry to EXEC: AL_CNT=0, bank latched, AL_STATUS=3'b001 (previous completed/aborted bits cleared).
- EXEC: AL_EXECUTE=1 for exactly one cycle → WAIT_BUSY.
- WAIT_BUSY: BUSY=1 → WAIT_DONE; timeout counter reloads.
- WAIT_DONE:
  - BUSY=0 and AL_DONE=1 → WRITE, capturing RD_DATA into WR_DATA.
  - If BUSY never rises and AL_DONE=1 is already seen, → WRITE as well (fast sequencer).
- WRITE: WR_EN=1, WR_ADDR=AL_CNT, CLR_AL_DONE=1, all in the same cycle → NEXT.
- NEXT:
  - If AL_CNT==NUM_WORDS-1 → COMPLETE.
  - Otherwise AL_CNT+1 → EXEC.
  - Per-word latency with immediate BUSY/DONE: 5 cycles.
- COMPLETE: AL_STATUS[1]=1, AL_STATUS[0]=0, pulse one cycle → IDLE.
- ABORT: AL_STATUS[2]=1, AL_STATUS[0]=0, CLR_AL_DONE=1 for one cycle → IDLE.
- Timeout:
  - A counter runs in WAIT_BUSY and WAIT_DONE.
  - Reaching TIMEOUT → ABORT.
  - The counter clears on every state change.
- AL_ABORT:
  - In any non-IDLE state except COMPLETE → ABORT next cycle. This has priority over other transitions.
  - In IDLE: no effect.
- AL_START while not IDLE: ignored, no status change.
- Simultaneous AL_START and AL_ABORT in IDLE: start wins.
- RST mid-load: immediate IDLE, status cleared, no WR_EN issued.
- AL_CNT never wraps; NUM_WORDS-1 is the last index.

Optional Feature:
- BPI_AL_CHECKSUM_EN defined:
  - The last word (index NUM_WORDS-1) is a checksum: two's-complement negation of the mod-2**DATA_W sum of words 0..NUM_WORDS-2.
  - The last word is written to the store as normal.
  - A running sum is kept over all words; a nonzero total at COMPLETE sets AL_STATUS[2] together with AL_STATUS[1].
- Not defined: no sum logic; AL_STATUS[2] is set only by abort or timeout.

Decomposition:
- Shared package bpi_al_pkg:
  - Read_Array_Cmd=16'h00FF and OP_READ=2'b10.
  - State enumeration.
  - Status bit indices (ST_RUN=0, ST_DONE=1, ST_ABORT=2).
- One sub-module, bpi_al_fsm: state register, counter and timeout.
- Top level holds address arithmetic, data capture, status and checksum.

Test Plan:
- Bank 0, NUM_WORDS=34, sequencer returns data=index+16'h100 with 2-cycle BUSY → 34 WR_EN pulses, AL_ADDR 7FC000..7FC021, WR_DATA 0100..0121, AL_STATUS=3'b010.
- AL_BANK=1 → first AL_ADDR=7F8000, last 7F8021.
- BUSY held 0 and AL_DONE 0 after word 5's EXECUTE → ABORT after TIMEOUT cycles, 5 writes total, AL_STATUS=3'b100, CLR_AL_DONE pulsed.
- AL_ABORT asserted in WAIT_DONE of word 10 → next cycle ABORT, no WR_EN for word 10, AL_STATUS=3'b100; a second AL_START reloads cleanly.
- RST asserted mid-load, then released → all outputs 0; AL_START during an active load → ignored, AL_CNT unaffected.
- With BPI_AL_CHECKSUM_EN, word 33 = correct negated sum → AL_STATUS=3'b010; corrupt word 33 → AL_STATUS=3'b110.
